// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single registered memory bus.
// Load/store has fixed priority; each grant runs to a bus ack or a timeout abort.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        stall_req
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IF  = 2'd1;
  localparam logic [1:0] S_BUSY_MEM = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        grant_if_q, grant_if_d;
  logic        flushed_q, flushed_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        if_ack_live;

  // Fetch result is held aside until DONE so a late flush can still discard it.
  assign if_ack_live = (state_q == S_DONE) && grant_if_q && !flushed_q && !flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    grant_if_d   = grant_if_q;
    flushed_d    = flushed_q;
    fetch_data_d = fetch_data_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = 8'd0;
        flushed_d = 1'b0;
        if (mem_req) begin
          state_d     = S_BUSY_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_sel_d   = mem_sel;
          bus_wdata_d = mem_wdata;
          grant_if_d  = 1'b0;
        end else if (if_req) begin
          state_d     = S_BUSY_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_sel_d   = 4'b1111;
          bus_wdata_d = 32'd0;
          grant_if_d  = 1'b1;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if ((state_q == S_BUSY_IF) && flush) flushed_d = 1'b1;
        if (bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b0;
          if (grant_if_q) fetch_data_d = bus_rdata;
          else if (!bus_we_q) mem_rdata_d = bus_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (grant_if_q) fetch_data_d = 32'd0;
          else mem_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bus_err_d = 1'b0;
        if (if_ack_live) if_rdata_d = fetch_data_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_sel_q    <= 4'd0;
      bus_wdata_q  <= 32'd0;
      grant_if_q   <= 1'b0;
      flushed_q    <= 1'b0;
      fetch_data_q <= 32'd0;
      if_rdata_q   <= 32'd0;
      mem_rdata_q  <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      grant_if_q   <= grant_if_d;
      flushed_q    <= flushed_d;
      fetch_data_q <= fetch_data_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign if_ack    = if_ack_live;
  assign if_rdata  = if_ack_live ? fetch_data_q : if_rdata_q;
  assign mem_ack   = (state_q == S_DONE) && !grant_if_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall_req = (mem_req & ~mem_ack) | (if_req & ~if_ack & ~flush);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, priority, wait states, timeout,
// flush and mid-transaction reset, with hand-computed expectations.
module tb_mem_bus_arbiter;
  logic        clk, rst;
  logic        if_req, mem_req, mem_we, flush, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic        bus_req, bus_we, if_ack, mem_ack, bus_err, stall_req;
  logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; flush = 0; bus_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; mem_sel = 0;
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // single fetch
    if_req = 1; if_addr = 32'h100; #1;
    chk("f_stall_idle", 32'(stall_req), 32'd1);
    tick();
    chk("f_bus_req", 32'(bus_req), 32'd1);
    chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_we", 32'(bus_we), 32'd0);
    chk("f_bus_sel", 32'(bus_sel), 32'hF);
    chk("f_stall_busy", 32'(stall_req), 32'd1);
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick();
    chk("f_if_ack", 32'(if_ack), 32'd1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_bus_req_drop", 32'(bus_req), 32'd0);
    chk("f_stall_ack", 32'(stall_req), 32'd0);
    bus_ack = 0; if_req = 0;
    tick();
    chk("f_if_ack_1cyc", 32'(if_ack), 32'd0);
    chk("f_if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // simultaneous requests: MEM store wins
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_sel = 4'h3; mem_wdata = 32'h1234;
    if_req = 1; if_addr = 32'h300;
    tick();
    chk("p_bus_we", 32'(bus_we), 32'd1);
    chk("p_bus_sel", 32'(bus_sel), 32'h3);
    chk("p_bus_addr", bus_addr, 32'h200);
    chk("p_bus_wdata", bus_wdata, 32'h1234);
    bus_ack = 1; bus_rdata = 32'h77777777;
    tick();
    chk("p_acks_mem", {30'd0, if_ack, mem_ack}, 32'd1);
    chk("p_mem_rdata_wr", mem_rdata, 32'd0);
    bus_ack = 0; mem_req = 0; mem_we = 0;
    tick();
    chk("p_idle_bus_req", 32'(bus_req), 32'd0);
    chk("p_idle_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    tick();
    chk("p_if_bus_addr", bus_addr, 32'h300);
    chk("p_if_bus_we", 32'(bus_we), 32'd0);
    chk("p_if_bus_sel", 32'(bus_sel), 32'hF);
    chk("p_if_bus_wdata", bus_wdata, 32'd0);
    bus_ack = 1; bus_rdata = 32'hCAFE0001;
    tick();
    chk("p_acks_if", {30'd0, if_ack, mem_ack}, 32'd2);
    chk("p_if_rdata", if_rdata, 32'hCAFE0001);
    bus_ack = 0; if_req = 0;
    tick();

    // wait states: MEM read with ack after 5 extra BUSY cycles
    mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_sel = 4'hF; mem_wdata = 32'h0;
    tick();
    chk("w_bus_addr_c1", bus_addr, 32'h400);
    mem_addr = 32'h999; mem_sel = 4'h1;
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk($sformatf("w_bus_addr_c%0d", i), bus_addr, 32'h400);
      chk($sformatf("w_bus_req_c%0d", i), {27'd0, bus_req, bus_sel}, 32'h1F);
    end
    bus_ack = 1; bus_rdata = 32'h55AA55AA;
    tick();
    chk("w_mem_ack", 32'(mem_ack), 32'd1);
    chk("w_mem_rdata", mem_rdata, 32'h55AA55AA);
    chk("w_bus_err", 32'(bus_err), 32'd0);
    bus_ack = 0; mem_req = 0;
    tick();

    // timeout on a MEM read
    mem_req = 1; mem_addr = 32'h500;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    chk("t_bus_req_c16", 32'(bus_req), 32'd1);
    tick();
    chk("t_bus_req_drop", 32'(bus_req), 32'd0);
    chk("t_ack_err", {30'd0, mem_ack, bus_err}, 32'd3);
    chk("t_mem_rdata", mem_rdata, 32'd0);
    mem_req = 0;
    tick();
    chk("t_clear", {30'd0, mem_ack, bus_err}, 32'd0);

    // ack in the same cycle as the timeout: ack wins
    if_req = 1; if_addr = 32'h580;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    tick();
    chk("tb_if_ack", 32'(if_ack), 32'd1);
    chk("tb_bus_err", 32'(bus_err), 32'd0);
    chk("tb_if_rdata", if_rdata, 32'h0BADF00D);
    bus_ack = 0; if_req = 0;
    tick();

    // flush during BUSY_IF
    if_req = 1; if_addr = 32'h600;
    tick();
    flush = 1; #1;
    chk("fl_stall", 32'(stall_req), 32'd0);
    tick();
    flush = 0; bus_ack = 1; bus_rdata = 32'h11112222;
    tick();
    chk("fl_bus_req_drop", 32'(bus_req), 32'd0);
    chk("fl_if_ack", 32'(if_ack), 32'd0);
    chk("fl_if_rdata", if_rdata, 32'h0BADF00D);
    bus_ack = 0; if_req = 0;
    tick();
    chk("fl_if_rdata_idle", if_rdata, 32'h0BADF00D);

    // flush arriving in DONE
    if_req = 1; if_addr = 32'h640;
    tick();
    bus_ack = 1; bus_rdata = 32'h33334444;
    tick();
    bus_ack = 0; if_req = 0; flush = 1; #1;
    chk("fd_if_ack", 32'(if_ack), 32'd0);
    chk("fd_if_rdata", if_rdata, 32'h0BADF00D);
    tick();
    flush = 0; #1;
    chk("fd_if_rdata_idle", if_rdata, 32'h0BADF00D);

    // reset during BUSY_MEM, then a stray ack
    mem_req = 1; mem_we = 1; mem_addr = 32'h700; mem_sel = 4'hF; mem_wdata = 32'hABCD;
    tick();
    chk("r_busy", 32'(bus_req), 32'd1);
    rst = 1; mem_req = 0; mem_we = 0;
    tick();
    chk("r_bus", {bus_req, bus_we, bus_sel}, 6'd0);
    chk("r_bus_addr", bus_addr, 32'd0);
    chk("r_bus_wdata", bus_wdata, 32'd0);
    chk("r_rdata", if_rdata | mem_rdata, 32'd0);
    rst = 0; bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    chk("r_stray_ack", {28'd0, mem_ack, if_ack, bus_err, bus_req}, 32'd0);
    bus_ack = 0;
    tick();
    chk("r_idle", {28'd0, mem_ack, if_ack, bus_err, bus_req}, 32'd0);
    chk("r_mem_rdata", mem_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without bus_ack before a forced abort (legal range 2..255).
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-003 SHALL have ports: if_req in 1, fetch request; if_addr in 32, fetch word address.
REQ-004 SHALL have ports: mem_req in 1, load/store request; mem_we in 1, store flag; mem_addr in 32; mem_sel in 4, byte enables; mem_wdata in 32.
REQ-005 SHALL have ports: flush in 1, pipeline flush; discards a pending fetch result.
REQ-006 SHALL have ports: bus_req out 1; bus_we out 1; bus_addr out 32; bus_sel out 4; bus_wdata out 32; bus_ack in 1; bus_rdata in 32.
REQ-007 SHALL have ports: if_ack out 1; if_rdata out 32; mem_ack out 1; mem_rdata out 32; bus_err out 1, timeout flag; stall_req out 1, pipeline stall request.

Function
REQ-008 SHALL implement the states IDLE, BUSY_IF, BUSY_MEM and DONE.
REQ-009 In IDLE, SHALL sample requests at the clock edge: mem_req=1 -> BUSY_MEM; else if_req=1 -> BUSY_IF; else stay in IDLE. MEM has fixed priority because it is the older instruction.
REQ-010 On the IDLE->BUSY_x edge, SHALL latch the addr, we, sel and wdata of the winner into the bus_* registers and set bus_req=1. Bus outputs SHALL come only from registers.
REQ-011 For an IF grant, SHALL drive bus_we=0, bus_sel=4'b1111 and bus_wdata=0.
REQ-012 During BUSY_x, bus_* outputs SHALL stay stable, and requester input changes SHALL be ignored.
REQ-013 In BUSY_x, when bus_ack=1 is sampled, SHALL on that edge:
  - go to DONE and clear bus_req;
  - capture bus_rdata into x_rdata (mem_rdata for a MEM write: unchanged).
REQ-014 In DONE, SHALL hold the matching x_ack=1 for exactly one cycle, then go to IDLE. No request SHALL be sampled in DONE.
REQ-015 Minimum latency SHALL be: request sampled at edge N, bus_req high in cycle N..N+1, bus_ack at edge N+1, x_ack in cycle N+1..N+2.
REQ-016 A timeout counter (8 bit) SHALL clear on entry to BUSY_x and increment every BUSY cycle without bus_ack.
REQ-017 When the counter reaches TIMEOUT-1 without bus_ack, SHALL on the next edge:
  - go to DONE and clear bus_req;
  - set x_rdata=0;
  - assert bus_err together with x_ack for that single DONE cycle.
REQ-018 If bus_ack and the timeout condition occur in the same cycle, bus_ack SHALL win and bus_err SHALL be 0.
REQ-019 If flush=1 in any cycle of BUSY_IF, or in DONE after an IF grant, the fetch SHALL complete on the bus, but if_ack SHALL be suppressed (0) and if_rdata left unchanged. A MEM transaction SHALL be unaffected by flush.
REQ-020 stall_req SHALL be combinational: (mem_req & ~mem_ack) | (if_req & ~if_ack & ~flush).
REQ-021 bus_ack sampled in IDLE or DONE SHALL be ignored.
REQ-022 if_ack and mem_ack SHALL never be 1 in the same cycle.

Reset
REQ-023 On rst=1 at an edge, SHALL set:
  - state=IDLE and counter=0;
  - bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0;
  - if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, bus_err=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no ack. A bus_ack arriving after reset SHALL be ignored.

Verification
REQ-025 Single fetch: if_req=1, if_addr=0x100, bus_ack one cycle after bus_req with bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_we=0, bus_sel=F; if_ack one cycle with if_rdata=0xDEADBEEF; stall_req=1 until the ack cycle.
REQ-026 Simultaneous requests: if_req and mem_req (store, addr=0x200, sel=0x3, wdata=0x1234) both asserted -> MEM is served first (bus_we=1, bus_sel=3). IF is granted only after DONE; acks occur in separate cycles.
REQ-027 Wait states: bus_ack delayed 5 cycles -> bus_* stay constant for all 6 BUSY cycles. Toggling mem_addr during BUSY does not change bus_addr.
REQ-028 Timeout: TIMEOUT=16, bus_ack never asserted -> bus_req drops after 16 BUSY cycles; mem_ack=1 and bus_err=1 in the same single cycle; mem_rdata=0.
REQ-029 Flush: flush pulsed during BUSY_IF -> the bus transaction completes, if_ack stays 0, and if_rdata keeps its old value.
REQ-030 Reset mid-op: rst asserted during BUSY_MEM, then bus_ack arrives -> all outputs are 0 the next cycle, no ack is issued, and the state is IDLE.
